// File: rtl/sb_pkg.sv
// Shared types and index helpers for the left-edge switch block.
// Keeping the index math here lets the RTL and its users agree on one wiring pattern.
package sb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } cfg_state_e;

  function automatic int cfg_bits(input int w);
    return 4 * w;
  endfunction

  // Right-track sources taken from the vertical channels.
  function automatic int top_src(input int i, input int w);
    return (i + w - 1) % w;
  endfunction

  function automatic int bot_src(input int i, input int w);
    return (i + 1) % w;
  endfunction

  // Vertical-track sources taken from the right channel.
  function automatic int rx_top(input int j, input int w);
    return (j + 1) % w;
  endfunction

  function automatic int rx_bot(input int j, input int w);
    return w - 1 - j;
  endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// Config scan chain: serial shadow register, frame counter FSM and the active
// register that routing reads. A frame only reaches act via an explicit commit.
module sb_cfg_chain
  import sb_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         head,
  input  logic         en,
  input  logic         commit,
  output logic [N-1:0] act,
  output logic         tail,
  output logic         loaded,
  output logic         busy,
  output logic         overrun
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] NMAX = CW'(N);

  cfg_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [N-1:0]  sr;
  logic          do_commit;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    do_commit = 1'b0;
    case (state)
      IDLE: if (en) begin
        state_n = LOAD;
        cnt_n   = CW'(1);
      end
      LOAD: if (en) begin
        cnt_n = cnt_inc;
        if (cnt_inc == NMAX) state_n = FULL;
      end
      FULL: if (commit) begin
        do_commit = 1'b1;
        // A shift in the commit cycle is the first bit of the next frame.
        state_n   = en ? LOAD : IDLE;
        cnt_n     = en ? CW'(1) : '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      act     <= '0;
      loaded  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (en) sr <= {sr[N-2:0], head};
      if (do_commit) begin
        act    <= sr;
        loaded <= 1'b1;
      end
      if (state == FULL && en && !commit) overrun <= 1'b1;
    end
  end

  assign tail = sr[N-1];
  assign busy = (state != IDLE);

endmodule

// File: rtl/sb_param_cfg.sv
// Left-edge switch block: every output side is a mux driven by the committed
// configuration held in sb_cfg_chain. No state lives at this level.
module sb_param_cfg
  import sb_pkg::*;
#(
  parameter int CHAN_W   = 4,
  parameter int NUM_PINS = 4
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                cfg_commit,
  input  logic [CHAN_W-1:0]   chany_top_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  input  logic [CHAN_W-1:0]   chany_bottom_in,
  input  logic [NUM_PINS-1:0] right_pin_in,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [CHAN_W-1:0]   chany_bottom_out,
  output logic                ccff_tail,
  output logic                cfg_loaded,
  output logic                cfg_busy,
  output logic                cfg_overrun
);

  localparam int CFG_BITS = cfg_bits(CHAN_W);

  logic [CFG_BITS-1:0] act;

  sb_cfg_chain #(.N(CFG_BITS)) u_chain (
    .clk     (prog_clk),
    .rst     (prog_reset),
    .head    (ccff_head),
    .en      (ccff_en),
    .commit  (cfg_commit),
    .act     (act),
    .tail    (ccff_tail),
    .loaded  (cfg_loaded),
    .busy    (cfg_busy),
    .overrun (cfg_overrun)
  );

  for (genvar i = 0; i < CHAN_W; i++) begin : g_trk
    localparam int TS = top_src(i, CHAN_W);
    localparam int BS = bot_src(i, CHAN_W);
    localparam int PS = i % NUM_PINS;
    localparam int RT = rx_top(i, CHAN_W);
    localparam int RB = rx_bot(i, CHAN_W);

    logic [1:0] rsel;
    assign rsel = act[2*i +: 2];

    // sel 3 parks the right track at zero.
    assign chanx_right_out[i] = (rsel == 2'd0) ? chany_top_in[TS]    :
                                (rsel == 2'd1) ? right_pin_in[PS]    :
                                (rsel == 2'd2) ? chany_bottom_in[BS] : 1'b0;

    assign chany_top_out[i]    = act[2*CHAN_W + i] ? chany_bottom_in[i] : chanx_right_in[RT];
    assign chany_bottom_out[i] = act[3*CHAN_W + i] ? chany_top_in[i]    : chanx_right_in[RB];
  end

endmodule

// File: tb/tb_sb_param_cfg.sv
// Bench for sb_param_cfg (CHAN_W=4, NUM_PINS=4): frames are shifted in, expected
// routing is queued at commit time and compared once the change is visible.
module tb_sb_param_cfg;
  import sb_pkg::*;

  logic       prog_clk = 1'b0;
  logic       prog_reset = 1'b0;
  logic       ccff_head = 1'b0, ccff_en = 1'b0, cfg_commit = 1'b0;
  logic [3:0] top_in = '0, right_in = '0, bot_in = '0, pin_in = '0;
  logic [3:0] top_out, right_out, bot_out;
  logic       ccff_tail, cfg_loaded, cfg_busy, cfg_overrun;
  logic [11:0] route;

  typedef struct {
    string       name;
    logic [11:0] route;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          pass_cnt = 0;
  int          total = 0;
  logic [15:0] m_act = '0;

  sb_param_cfg #(.CHAN_W(4), .NUM_PINS(4)) dut (
    .prog_clk         (prog_clk),
    .prog_reset       (prog_reset),
    .ccff_head        (ccff_head),
    .ccff_en          (ccff_en),
    .cfg_commit       (cfg_commit),
    .chany_top_in     (top_in),
    .chanx_right_in   (right_in),
    .chany_bottom_in  (bot_in),
    .right_pin_in     (pin_in),
    .chany_top_out    (top_out),
    .chanx_right_out  (right_out),
    .chany_bottom_out (bot_out),
    .ccff_tail        (ccff_tail),
    .cfg_loaded       (cfg_loaded),
    .cfg_busy         (cfg_busy),
    .cfg_overrun      (cfg_overrun)
  );

  always #5 prog_clk = ~prog_clk;

  assign route = {top_out, right_out, bot_out};

  // Reference routing: {top_out, right_out, bottom_out} for a given act word.
  function automatic logic [11:0] exp_route(input logic [15:0] a, input logic [3:0] t,
                                            input logic [3:0] r, input logic [3:0] b,
                                            input logic [3:0] p);
    logic [3:0] ro, to, bo;
    for (int i = 0; i < 4; i++) begin
      case (a[2*i +: 2])
        2'd0:    ro[i] = t[(i + 3) % 4];
        2'd1:    ro[i] = p[i % 4];
        2'd2:    ro[i] = b[(i + 1) % 4];
        default: ro[i] = 1'b0;
      endcase
      to[i] = a[8 + i]  ? b[i] : r[(i + 1) % 4];
      bo[i] = a[12 + i] ? t[i] : r[3 - i];
    end
    return {to, ro, bo};
  endfunction

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Shift bits f[15-k] for k in [from, to): MSB of the frame goes first.
  task automatic shift_bits(input logic [15:0] f, input int from, input int to);
    for (int k = from; k < to; k++) begin
      ccff_en   = 1'b1;
      ccff_head = f[15 - k];
      step();
    end
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic push_exp(input string name, input logic [15:0] a);
    exp_t x;
    x.name  = name;
    x.route = exp_route(a, top_in, right_in, bot_in, pin_in);
    sb_q.push_back(x);
  endtask

  task automatic test_reset();
    prog_reset = 1'b1;
    ccff_en    = 1'b1;
    ccff_head  = 1'b1;
    step();
    step();
    prog_reset = 1'b0;
    ccff_en    = 1'b0;
    ccff_head  = 1'b0;
    top_in = 4'b1000; bot_in = '0; right_in = '0; pin_in = '0;
    #1;
    push_exp("reset_route", 16'h0000);
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
    total++; if (right_out[0] !== 1'b1) $display("FAIL reset_right0: got %b want 1", right_out[0]); else pass_cnt++;
    total++; if (cfg_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", cfg_busy); else pass_cnt++;
    total++; if (cfg_loaded !== 1'b0) $display("FAIL reset_loaded: got %b want 0", cfg_loaded); else pass_cnt++;
    total++; if (cfg_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", cfg_overrun); else pass_cnt++;
    total++; if (ccff_tail !== 1'b0) $display("FAIL reset_tail: got %b want 0", ccff_tail); else pass_cnt++;
  endtask

  task automatic test_load_commit();
    top_in = '0; pin_in = 4'b0001;
    shift_bits(16'h0001, 0, 16);
    push_exp("precommit_route", m_act);
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
    total++; if (cfg_busy !== 1'b1) $display("FAIL full_busy: got %b want 1", cfg_busy); else pass_cnt++;
    total++; if (dut.u_chain.state !== FULL) $display("FAIL full_state: got %0d want %0d", dut.u_chain.state, FULL); else pass_cnt++;
    total++; if (int'(dut.u_chain.cnt) != 16) $display("FAIL full_cnt: got %0d want 16", dut.u_chain.cnt); else pass_cnt++;
    total++; if (right_out[0] !== 1'b0) $display("FAIL precommit_right0: got %b want 0", right_out[0]); else pass_cnt++;
    cfg_commit = 1'b1;
    push_exp("commit_0001", 16'h0001);
    step();
    cfg_commit = 1'b0;
    m_act = 16'h0001;
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
    total++; if (right_out[0] !== 1'b1) $display("FAIL commit_right0: got %b want 1", right_out[0]); else pass_cnt++;
    total++; if (cfg_loaded !== 1'b1) $display("FAIL commit_loaded: got %b want 1", cfg_loaded); else pass_cnt++;
    total++; if (cfg_busy !== 1'b0) $display("FAIL commit_busy: got %b want 0", cfg_busy); else pass_cnt++;
  endtask

  task automatic test_sel3();
    top_in = 4'hF; bot_in = 4'hF; pin_in = 4'hF; right_in = 4'h0;
    shift_bits(16'h0003, 0, 16);
    cfg_commit = 1'b1;
    push_exp("sel3_route", 16'h0003);
    step();
    cfg_commit = 1'b0;
    m_act = 16'h0003;
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
    total++; if (right_out !== 4'b1110) $display("FAIL sel3_right: got %b want 1110", right_out); else pass_cnt++;
  endtask

  task automatic test_early_commit();
    logic [15:0] f;
    f = 16'h6C93;
    top_in = 4'(($urandom)); right_in = 4'(($urandom)); bot_in = 4'(($urandom)); pin_in = 4'(($urandom));
    shift_bits(f, 0, 10);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    push_exp("early_commit_ignored", m_act);
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
    total++; if (dut.u_chain.state !== LOAD) $display("FAIL early_state: got %0d want %0d", dut.u_chain.state, LOAD); else pass_cnt++;
    total++; if (int'(dut.u_chain.cnt) != 10) $display("FAIL early_cnt: got %0d want 10", dut.u_chain.cnt); else pass_cnt++;
    shift_bits(f, 10, 16);
    cfg_commit = 1'b1;
    push_exp("late_commit", f);
    step();
    cfg_commit = 1'b0;
    m_act = f;
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [15:0] g;
    g = 16'hB2E4;
    shift_bits(g, 0, 16);
    total++; if (ccff_tail !== g[15]) $display("FAIL full_tail: got %b want %b", ccff_tail, g[15]); else pass_cnt++;
    total++; if (cfg_overrun !== 1'b0) $display("FAIL pre_overrun: got %b want 0", cfg_overrun); else pass_cnt++;
    ccff_en = 1'b1; ccff_head = 1'b0;
    step();
    ccff_en = 1'b0;
    total++; if (cfg_overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", cfg_overrun); else pass_cnt++;
    total++; if (dut.u_chain.state !== FULL) $display("FAIL overrun_state: got %0d want %0d", dut.u_chain.state, FULL); else pass_cnt++;
    total++; if (int'(dut.u_chain.cnt) != 16) $display("FAIL overrun_cnt: got %0d want 16", dut.u_chain.cnt); else pass_cnt++;
    total++; if (ccff_tail !== g[14]) $display("FAIL drain_tail: got %b want %b", ccff_tail, g[14]); else pass_cnt++;
    cfg_commit = 1'b1; ccff_en = 1'b1; ccff_head = 1'b1;
    push_exp("commit_with_shift", {g[14:0], 1'b0});
    step();
    cfg_commit = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0;
    m_act = {g[14:0], 1'b0};
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
    total++; if (dut.u_chain.state !== LOAD) $display("FAIL cs_state: got %0d want %0d", dut.u_chain.state, LOAD); else pass_cnt++;
    total++; if (int'(dut.u_chain.cnt) != 1) $display("FAIL cs_cnt: got %0d want 1", dut.u_chain.cnt); else pass_cnt++;
    total++; if (cfg_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", cfg_overrun); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    shift_bits(16'hFFFF, 0, 6);
    total++; if (int'(dut.u_chain.cnt) != 7) $display("FAIL mid_cnt: got %0d want 7", dut.u_chain.cnt); else pass_cnt++;
    right_in = 4'b0110; top_in = 4'b1011; bot_in = 4'b0101; pin_in = 4'b1001;
    prog_reset = 1'b1; ccff_en = 1'b1; ccff_head = 1'b1; cfg_commit = 1'b1;
    step();
    prog_reset = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0;
    m_act = '0;
    push_exp("mid_reset_route", 16'h0000);
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
    total++; if (int'(dut.u_chain.cnt) != 0) $display("FAIL rst_cnt: got %0d want 0", dut.u_chain.cnt); else pass_cnt++;
    total++; if (dut.u_chain.state !== IDLE) $display("FAIL rst_state: got %0d want %0d", dut.u_chain.state, IDLE); else pass_cnt++;
    total++; if (cfg_loaded !== 1'b0) $display("FAIL rst_loaded: got %b want 0", cfg_loaded); else pass_cnt++;
    total++; if (cfg_overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", cfg_overrun); else pass_cnt++;
    total++; if (cfg_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", cfg_busy); else pass_cnt++;
    total++; if (ccff_tail !== 1'b0) $display("FAIL rst_tail: got %b want 0", ccff_tail); else pass_cnt++;
    // top_out[j] = right_in[(j+1)%4] for right_in = 0110
    total++; if (top_out !== 4'b0011) $display("FAIL rst_top_out: got %b want 0011", top_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] fr [4];
    for (int k = 0; k < 4; k++) fr[k] = 16'($urandom);
    top_in = 4'($urandom); right_in = 4'($urandom); bot_in = 4'($urandom); pin_in = 4'($urandom);
    shift_bits(fr[0], 0, 16);
    for (int k = 1; k < 4; k++) begin
      cfg_commit = 1'b1; ccff_en = 1'b1; ccff_head = fr[k][15];
      push_exp($sformatf("b2b_frame%0d", k - 1), fr[k-1]);
      step();
      cfg_commit = 1'b0; ccff_en = 1'b0;
      e = sb_q.pop_front();
      total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
      total++; if (int'(dut.u_chain.cnt) != 1) $display("FAIL b2b_cnt%0d: got %0d want 1", k, dut.u_chain.cnt); else pass_cnt++;
      shift_bits(fr[k], 1, 16);
    end
    cfg_commit = 1'b1;
    push_exp("b2b_frame3", fr[3]);
    step();
    cfg_commit = 1'b0;
    e = sb_q.pop_front();
    total++; if (route !== e.route) $display("FAIL %s: got %h want %h", e.name, route, e.route); else pass_cnt++;
    total++; if (cfg_busy !== 1'b0) $display("FAIL b2b_busy: got %b want 0", cfg_busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_sel3();
    test_early_commit();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
